// File: rtl/lpc_stream_bridge.sv
// lpc_stream_bridge: buffered stream stage between the LPC read-master source and
// the write-master sink. A one-entry stage register computes passthrough or
// first-order pre-emphasis (y = x[n] - a*x[n-1], saturated), then feeds a
// first-word-fall-through FIFO with sink backpressure. The source cannot stall,
// so samples arriving without room are dropped and flagged in a sticky overflow.
//
// Optional build macro:
//   LPC_BRIDGE_DROP_CNT_EN - adds output drop_count[15:0], a saturating count of
//                            dropped samples cleared by reset and flush.

module lpc_stream_bridge #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,  // power of 2, >= 4
  parameter int COEF_W     = 16,
  parameter int COEF_FRAC  = 15
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic                            flush,
  input  logic                            mode,
  input  logic [COEF_W-1:0]               coef,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [DATA_W-1:0]               out_data,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            overflow
`ifdef LPC_BRIDGE_DROP_CNT_EN
  ,
  output logic [15:0]                     drop_count
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int DIFF_W = PROD_W + 1;
  localparam int EXT_W  = DIFF_W - DATA_W + 1;

  // Stage register and pre-emphasis history
  logic                     stage_valid_q;
  logic [DATA_W-1:0]        stage_data_q;
  logic signed [DATA_W-1:0] x_prev_q;
  logic                     overflow_q;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [LVL_W-1:0]         level_q;

  // Handshake decode
  logic                     pop;
  logic                     push;
  logic                     accept;
  logic                     drop;
  logic [LVL_W:0]           held;

  // Pre-emphasis datapath
  logic signed [COEF_W-1:0] coef_s;
  logic signed [DATA_W-1:0] in_data_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_sh;
  logic signed [DIFF_W-1:0] diff;
  logic                     diff_fits;
  logic [DATA_W-1:0]        stage_d;

  // ---------------------------------------------------------------------------
  // Handshakes. The stage register counts as occupancy so that a sample that is
  // accepted always has a FIFO slot by the time it leaves the stage; with this
  // rule level + stage_valid never exceeds FIFO_DEPTH, so a full FIFO never
  // holds a staged sample and the stage never writes into a full FIFO.
  // ---------------------------------------------------------------------------
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  assign held      = {1'b0, level_q} + {{LVL_W{1'b0}}, stage_valid_q};
  assign in_ready  = (held < (LVL_W+1)'(FIFO_DEPTH)) | pop;
  assign accept    = in_valid & in_ready & ~flush;
  assign drop      = in_valid & ~in_ready & ~flush;
  assign push      = stage_valid_q & ~flush;

  // Head of FIFO is presented directly; forced to zero while empty so the
  // uninitialised storage never shows on the port.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;

  assign coef_s    = coef;
  assign in_data_s = in_data;

  // Compute the stage value for the sample on the input this cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a value on all paths first, so no
    // latch is inferred when a branch below does not assign it.
    stage_d   = in_data;
    prod      = PROD_W'(coef_s) * PROD_W'(x_prev_q);
    // Arithmetic shift of the signed product truncates toward minus infinity.
    prod_sh   = prod >>> COEF_FRAC;
    diff      = DIFF_W'(in_data_s) - DIFF_W'(prod_sh);
    // The result fits DATA_W when all bits above the DATA_W sign bit agree.
    diff_fits = (diff[DIFF_W-1:DATA_W-1] == {EXT_W{diff[DIFF_W-1]}});
    if (mode) begin
      if (diff_fits) begin
        stage_d = diff[DATA_W-1:0];
      end else if (diff[DIFF_W-1]) begin
        stage_d = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        stage_d = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end
  end

  // Stage register, history sample and sticky overflow flag.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_reset_n) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      x_prev_q      <= '0;
      overflow_q    <= 1'b0;
    end else if (flush) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      x_prev_q      <= '0;
      overflow_q    <= 1'b0;
    end else begin
      stage_valid_q <= accept;
      if (accept) begin
        stage_data_q <= stage_d;
        x_prev_q     <= in_data_s;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage write from the stage register.
  always_ff @(posedge clk_clk) begin
    // NOTE: the storage array has no reset; out_valid and out_data are derived
    // from level_q, so stale contents are never observable.
    if (push) begin
      mem_q[wr_ptr_q] <= stage_data_q;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef LPC_BRIDGE_DROP_CNT_EN
  logic [15:0] drop_count_q;

  // Saturating count of dropped samples.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      drop_count_q <= '0;
    end else if (flush) begin
      drop_count_q <= '0;
    end else if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_lpc_stream_bridge.sv
// Self-checking bench for lpc_stream_bridge (default parameters). Stimulus
// pushes hand-computed expected samples into a queue; an independent monitor
// pops and compares whenever the sink takes a sample.
// Build with LPC_BRIDGE_DROP_CNT_EN defined to also exercise drop_count.

module tb_lpc_stream_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        mode;
  logic [15:0] coef;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
`ifdef LPC_BRIDGE_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  lpc_stream_bridge dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .flush        (flush),
    .mode         (mode),
    .coef         (coef),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow)
`ifdef LPC_BRIDGE_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every sample the sink takes, and checks that a stalled
  // head does not change.
  logic        stall_q = 1'b0;
  logic [15:0] stall_data = '0;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (stall_q) check("hold_stable", 32'(out_data), 32'(stall_data));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h expected none", out_data);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
    if (level > 5'd16) begin
      bad++;
      $display("FAIL level_bound: got %0d expected <= 16", level);
    end
    stall_q    = rst_n && out_valid && !out_ready;
    stall_data = out_data;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one cycle; check the advisory ready and, if the
  // sample should be taken, queue its expected output.
  task automatic drive(input logic [15:0] d, input logic exp_acc, input logic [15:0] exp_y);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(exp_acc));
    if (exp_acc) exp_q.push_back(exp_y);
    cycle();
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || level != 0) && n < 200) begin
      cycle();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    mode      = 1'b0;
    coef      = 16'h0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    repeat (3) cycle();

    // Reset values
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    cycle();

    // 1: passthrough, 1,2,3 back-to-back; head appears two cycles after accept
    mode      = 1'b0;
    out_ready = 1'b1;
    drive(16'd1, 1'b1, 16'd1);
    in_data = 16'd2;
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    check("in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(16'd2);
    cycle();
    in_data = 16'd3;
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    check("in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(16'd3);
    cycle();
    drain();
    do_flush();

    // 2: pre-emphasis with rounding toward -inf and saturation both ways
    mode = 1'b1;
    coef = 16'h4000;                         // 0.5
    drive(16'd100,  1'b1, 16'd100);          // x_prev = 0
    drive(16'd100,  1'b1, 16'd50);           // 100 - 50
    drive(16'h8000, 1'b1, 16'h8000);         // -32768 - 50 saturates low
    drive(16'hFFFD, 1'b1, 16'h3FFD);         // -3 + 16384 = 16381
    drive(16'h0000, 1'b1, 16'h0002);         // 0 - floor(-1.5) = 2
    drive(16'h7FFF, 1'b1, 16'h7FFF);         // 32767 - 0
    coef = 16'hC000;                         // -0.5, takes effect on next accept
    drive(16'd100,  1'b1, 16'h4064);         // 100 + 16384 = 16484
    drive(16'h7FFF, 1'b1, 16'h7FFF);         // 32767 + 50 saturates high
    drain();

    // 3: sink stalled, 20 samples: 16 held, last 4 dropped
    mode      = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) drive(16'(k), (k <= 16), 16'(k));
    in_valid = 1'b0;
    @(negedge clk);
    check("full_level", 32'(level), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_head", 32'(out_data), 32'd1);
`ifdef LPC_BRIDGE_DROP_CNT_EN
    check("drop_count4", 32'(drop_count), 32'd4);
`endif
    cycle();

    // 4: full FIFO, sink released while the source keeps pushing. The first
    // pop frees a slot, after which push and pop coincide and the stage plus
    // FIFO keep holding 16 samples with no drop and order preserved.
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1;
      in_data  = 16'(100 + j);
      @(negedge clk);
      check("steady_level", 32'(level), (j == 0) ? 32'd16 : 32'd15);
      check("steady_in_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(16'(100 + j));
      cycle();
    end
    drain();

    // 5: flush with 7 held and a sample on the input in the same cycle
    mode      = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k <= 7; k++) drive(16'(10 * k), 1'b1, 16'(10 * k));
    in_valid = 1'b0;
    cycle();
    @(negedge clk);
    check("pre_flush_level", 32'(level), 32'd7);
    check("pre_flush_overflow", 32'(overflow), 32'd1);
    cycle();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd555;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_level", 32'(level), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_overflow", 32'(overflow), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
`ifdef LPC_BRIDGE_DROP_CNT_EN
    check("flush_drop_count", 32'(drop_count), 32'd0);
`endif
    cycle();
    @(negedge clk);
    check("flush_no_stage", 32'(level), 32'd0);
    cycle();
    // History cleared: with x_prev = 0 pre-emphasis passes the sample through
    mode      = 1'b1;
    coef      = 16'h4000;
    out_ready = 1'b1;
    drive(16'd1000, 1'b1, 16'd1000);
    drain();

    // Reset mid-stream
    mode      = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) drive(16'(k + 40), 1'b1, 16'(k + 40));
    in_valid = 1'b1;
    in_data  = 16'd77;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    in_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    out_ready = 1'b1;
    drive(16'd7, 1'b1, 16'd7);
    drain();

`ifdef LPC_BRIDGE_DROP_CNT_EN
    // 6: saturating drop counter, then reset in the middle of the burst
    out_ready = 1'b0;
    for (int k = 1; k <= 16; k++) drive(16'(k), 1'b1, 16'(k));
    in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check("drop_count_sat", 32'(drop_count), 32'hFFFF);
    check("drop_overflow", 32'(overflow), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("drop_rst_count", 32'(drop_count), 32'd0);
    check("drop_rst_overflow", 32'(overflow), 32'd0);
    check("drop_rst_level", 32'(level), 32'd0);
    exp_q.delete();
    in_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
